dnn_mem_arbiter: RTL and testbench

Two-to-one AMI memory port arbiter sitting directly downstream of the DNNWeaver accelerator top inside the DNNDrive application. It merges the accelerator's two memory request channels onto the single AMI request/response port owned by the application. Read responses come back in issue order on that port; a tag FIFO records which channel issued each read, so every response is routed back to its originator. It also exposes outstanding-read and protocol-error status for soft-register readback.

---
 rtl/AMITypes.sv | 22 ++
 rtl/dnn_mem_arbiter_pkg.sv | 10 +
 rtl/dnn_tag_fifo.sv | 64 ++++++
 rtl/dnn_mem_arbiter.sv | 100 ++++++++++
 tb/tb_dnn_mem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/AMITypes.sv
// AMI request/response types shared across the DNNDrive application memory path.
package AMITypes;

  localparam int AMI_ADDR_WIDTH = 64;
  localparam int AMI_DATA_WIDTH = 512;
  localparam int AMI_SIZE_WIDTH = 64;

  typedef struct packed {
    logic                      valid;
    logic                      isWrite;
    logic [AMI_ADDR_WIDTH-1:0] addr;
    logic [AMI_DATA_WIDTH-1:0] data;
    logic [AMI_SIZE_WIDTH-1:0] size;
  } AMIRequest;

  typedef struct packed {
    logic                      valid;
    logic [AMI_DATA_WIDTH-1:0] data;
    logic [AMI_SIZE_WIDTH-1:0] size;
  } AMIResponse;

endpackage

// File: rtl/dnn_mem_arbiter_pkg.sv
// Shared constants and types for the DNNWeaver two-channel AMI arbiter.
package dnn_mem_arbiter_pkg;

  localparam int DNN_NUM_CH        = 2;
  localparam int DNN_TAG_LOG_DEPTH = 5;

  // Index of an upstream request channel; doubles as the tag stored per read.
  typedef logic ch_idx_t;

endpackage

// File: rtl/dnn_tag_fifo.sv
// Tag FIFO remembering which channel issued each outstanding read, in issue order.
module dnn_tag_fifo
  import dnn_mem_arbiter_pkg::*;
#(
  parameter int LOG_DEPTH = DNN_TAG_LOG_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  ch_idx_t          push_data,
  input  logic             pop,
  output ch_idx_t          head,
  output logic             empty,
  output logic             full,
  output logic [LOG_DEPTH:0] count
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] DEPTH_CNT = (LOG_DEPTH + 1)'(DEPTH);

  ch_idx_t              mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr;
  logic [LOG_DEPTH-1:0] rd_ptr;
  logic [LOG_DEPTH:0]   count_next;
  logic                 do_push;
  logic                 do_pop;

  // Guard against overflow/underflow even if the caller forgets to.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == DEPTH_CNT);
      empty <= (count_next == '0);
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/dnn_mem_arbiter.sv
// Round-robin merge of the two DNNWeaver memory channels onto one AMI port,
// with in-order read responses steered back to the issuing channel.
module dnn_mem_arbiter
  import dnn_mem_arbiter_pkg::*;
  import AMITypes::*;
#(
  parameter int NUM_CH        = DNN_NUM_CH,
  parameter int TAG_LOG_DEPTH = DNN_TAG_LOG_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  AMIRequest  [NUM_CH-1:0]     in_reqs,
  output logic       [NUM_CH-1:0]     in_req_grants,
  output AMIResponse [NUM_CH-1:0]     in_resps,
  input  logic       [NUM_CH-1:0]     in_resp_grants,
  output AMIRequest                   out_req,
  input  logic                        out_req_grant,
  input  AMIResponse                  out_resp,
  output logic                        out_resp_grant,
  output logic [TAG_LOG_DEPTH:0]      outstanding,
  output logic                        err_orphan
);

  // Handshake: a request transfers when out_req.valid && out_req_grant; a
  // response transfers when out_resp.valid && out_resp_grant. Upstream holds
  // requests stable until granted, so nothing is registered on either path.

  ch_idx_t   last;
  ch_idx_t   sel;
  AMIRequest sel_req;
  logic      eligible;
  logic      req_fire;
  logic      tag_push;
  logic      tag_pop;
  ch_idx_t   tag_head;
  logic      tag_empty;
  logic      tag_full;
  logic      orphan;

  // Request side: pick a channel, then decide whether it may go out.
  always_comb begin
    if (in_reqs[0].valid && in_reqs[1].valid) sel = ~last;
    else                                      sel = in_reqs[1].valid;
    sel_req  = in_reqs[sel];
    // An ineligible pick blocks the port rather than yielding to the other channel.
    eligible = !reset && sel_req.valid && (sel_req.isWrite || !tag_full);
    req_fire = eligible && out_req_grant;
    tag_push = req_fire && !sel_req.isWrite;
  end

  always_comb begin
    out_req       = sel_req;
    out_req.valid = eligible;
    in_req_grants      = '0;
    in_req_grants[sel] = req_fire;
  end

  // Response side: the FIFO head names the owner of the next response.
  always_comb begin
    in_resps       = '0;
    out_resp_grant = 1'b0;
    tag_pop        = 1'b0;
    orphan         = 1'b0;
    if (!reset) begin
      if (tag_empty) begin
        out_resp_grant = out_resp.valid;
        orphan         = out_resp.valid;
      end else begin
        in_resps[tag_head] = out_resp;
        out_resp_grant     = in_resp_grants[tag_head];
        tag_pop            = out_resp.valid && in_resp_grants[tag_head];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last       <= 1'b1;
      err_orphan <= 1'b0;
    end else begin
      if (req_fire) last <= sel;
      if (orphan)   err_orphan <= 1'b1;
    end
  end

  dnn_tag_fifo #(
    .LOG_DEPTH (TAG_LOG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tag_push),
    .push_data (sel),
    .pop       (tag_pop),
    .head      (tag_head),
    .empty     (tag_empty),
    .full      (tag_full),
    .count     (outstanding)
  );

endmodule

// File: tb/tb_dnn_mem_arbiter.sv
// Directed bench for dnn_mem_arbiter: arbitration order, tag routing, full and orphan cases.
module tb_dnn_mem_arbiter;
  import AMITypes::*;

  logic                 clk;
  logic                 reset;
  AMIRequest  [1:0]     in_reqs;
  logic       [1:0]     in_req_grants;
  AMIResponse [1:0]     in_resps;
  logic       [1:0]     in_resp_grants;
  AMIRequest            out_req;
  logic                 out_req_grant;
  AMIResponse           out_resp;
  logic                 out_resp_grant;
  logic       [5:0]     outstanding;
  logic                 err_orphan;

  int checks_total;
  int checks_passed;

  dnn_mem_arbiter #(
    .NUM_CH        (2),
    .TAG_LOG_DEPTH (5)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_reqs        (in_reqs),
    .in_req_grants  (in_req_grants),
    .in_resps       (in_resps),
    .in_resp_grants (in_resp_grants),
    .out_req        (out_req),
    .out_req_grant  (out_req_grant),
    .out_resp       (out_resp),
    .out_resp_grant (out_resp_grant),
    .outstanding    (outstanding),
    .err_orphan     (err_orphan)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else checks_passed++;
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    in_reqs        = '0;
    in_resp_grants = 2'b00;
    out_req_grant  = 1'b0;
    out_resp       = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drive_req(input int ch, input logic is_write, input logic [63:0] addr);
    in_reqs[ch].valid   = 1'b1;
    in_reqs[ch].isWrite = is_write;
    in_reqs[ch].addr    = addr;
    in_reqs[ch].data    = {448'd0, addr};
    in_reqs[ch].size    = 64'd64;
  endtask

  task automatic drive_resp(input logic [63:0] data);
    out_resp.valid = 1'b1;
    out_resp.data  = {448'd0, data};
    out_resp.size  = 64'd64;
  endtask

  logic [1:0] exp_grant;
  int         grant_cnt;

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    reset = 1'b1;
    idle_inputs();

    // Reset state, checked while reset is still held
    tick();
    tick();
    check("rst_out_req_valid", 64'(out_req.valid), 64'd0);
    check("rst_req_grants", 64'(in_req_grants), 64'd0);
    check("rst_resp_valid", 64'({in_resps[1].valid, in_resps[0].valid}), 64'd0);
    check("rst_out_resp_grant", 64'(out_resp_grant), 64'd0);
    check("rst_outstanding", 64'(outstanding), 64'd0);
    check("rst_err_orphan", 64'(err_orphan), 64'd0);
    reset = 1'b0;
    tick();

    // Single read on channel 0
    drive_req(0, 1'b0, 64'h1000);
    out_req_grant = 1'b1;
    settle();
    check("single_grant", 64'(in_req_grants), 64'h1);
    check("single_out_addr", out_req.addr, 64'h1000);
    tick();
    idle_inputs();
    settle();
    check("single_outstanding_1", 64'(outstanding), 64'd1);
    drive_resp(64'hAA);
    in_resp_grants = 2'b11;
    settle();
    check("single_resp0_valid", 64'(in_resps[0].valid), 64'd1);
    check("single_resp0_data", in_resps[0].data[63:0], 64'hAA);
    check("single_resp1_valid", 64'(in_resps[1].valid), 64'd0);
    check("single_out_resp_grant", 64'(out_resp_grant), 64'd1);
    tick();
    idle_inputs();
    settle();
    check("single_outstanding_0", 64'(outstanding), 64'd0);

    // Both channels contending: grants alternate starting with channel 0
    do_reset();
    drive_req(0, 1'b0, 64'h2000);
    drive_req(1, 1'b0, 64'h3000);
    out_req_grant = 1'b1;
    exp_grant = 2'b01;
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("alt_grant_%0d", i), 64'(in_req_grants), 64'(exp_grant));
      tick();
      exp_grant = ~exp_grant;
    end
    idle_inputs();
    settle();
    check("alt_outstanding_4", 64'(outstanding), 64'd4);
    in_resp_grants = 2'b11;
    for (int i = 0; i < 4; i++) begin
      drive_resp(64'h100 + 64'(i));
      settle();
      check($sformatf("alt_route_valid_%0d", i),
            64'({in_resps[1].valid, in_resps[0].valid}), (i % 2 == 0) ? 64'h1 : 64'h2);
      check($sformatf("alt_route_data_%0d", i),
            (i % 2 == 0) ? in_resps[0].data[63:0] : in_resps[1].data[63:0], 64'h100 + 64'(i));
      tick();
    end
    idle_inputs();
    settle();
    check("alt_outstanding_0", 64'(outstanding), 64'd0);

    // Fill the tag FIFO from channel 1
    do_reset();
    drive_req(1, 1'b0, 64'h4000);
    out_req_grant = 1'b1;
    grant_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      settle();
      if (in_req_grants == 2'b10) grant_cnt++;
      tick();
    end
    check("full_grant_count", 64'(grant_cnt), 64'd32);
    check("full_outstanding", 64'(outstanding), 64'd32);
    check("full_blocked_valid", 64'(out_req.valid), 64'd0);
    check("full_blocked_grant", 64'(in_req_grants), 64'd0);

    // Write from channel 0 still goes through while full
    drive_req(0, 1'b1, 64'h5000);
    settle();
    check("full_write_grant", 64'(in_req_grants), 64'h1);
    check("full_write_is_write", 64'(out_req.isWrite), 64'd1);
    tick();
    in_reqs[0] = '0;
    settle();
    check("full_write_no_tag", 64'(outstanding), 64'd32);
    check("full_still_blocked", 64'(in_req_grants), 64'd0);

    // One response frees a slot; the pending read goes the following cycle
    drive_resp(64'h77);
    in_resp_grants = 2'b11;
    settle();
    check("full_pop_resp_grant", 64'(out_resp_grant), 64'd1);
    check("full_pop_route", 64'({in_resps[1].valid, in_resps[0].valid}), 64'h2);
    check("full_pop_same_cycle_grant", 64'(in_req_grants), 64'd0);
    tick();
    out_resp = '0;
    settle();
    check("full_after_pop_outstanding", 64'(outstanding), 64'd31);
    check("full_after_pop_grant", 64'(in_req_grants), 64'h2);

    // Response held while the owning channel stalls
    do_reset();
    drive_req(0, 1'b0, 64'h6000);
    out_req_grant = 1'b1;
    tick();
    idle_inputs();
    drive_resp(64'h55);
    in_resp_grants = 2'b10;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("hold_resp_grant_%0d", i), 64'(out_resp_grant), 64'd0);
      check($sformatf("hold_resp_valid_%0d", i), 64'(in_resps[0].valid), 64'd1);
      tick();
    end
    check("hold_outstanding", 64'(outstanding), 64'd1);
    in_resp_grants = 2'b01;
    settle();
    check("hold_release_grant", 64'(out_resp_grant), 64'd1);
    tick();
    idle_inputs();
    settle();
    check("hold_outstanding_0", 64'(outstanding), 64'd0);

    // Push and pop in one cycle keep the count; new head routes to channel 1
    drive_req(0, 1'b0, 64'h7000);
    out_req_grant = 1'b1;
    tick();
    idle_inputs();
    drive_req(1, 1'b0, 64'h8000);
    out_req_grant = 1'b1;
    drive_resp(64'h11);
    in_resp_grants = 2'b11;
    settle();
    check("pushpop_grant", 64'(in_req_grants), 64'h2);
    check("pushpop_route", 64'({in_resps[1].valid, in_resps[0].valid}), 64'h1);
    tick();
    idle_inputs();
    settle();
    check("pushpop_outstanding", 64'(outstanding), 64'd1);
    drive_resp(64'h22);
    in_resp_grants = 2'b11;
    settle();
    check("pushpop_head_ch1", 64'({in_resps[1].valid, in_resps[0].valid}), 64'h2);
    tick();
    idle_inputs();

    // Orphan response with no reads outstanding
    do_reset();
    drive_resp(64'h99);
    settle();
    check("orphan_resp_grant", 64'(out_resp_grant), 64'd1);
    check("orphan_resps_invalid", 64'({in_resps[1].valid, in_resps[0].valid}), 64'd0);
    check("orphan_err_before", 64'(err_orphan), 64'd0);
    tick();
    out_resp = '0;
    tick();
    tick();
    check("orphan_err_sticky", 64'(err_orphan), 64'd1);
    check("orphan_outstanding", 64'(outstanding), 64'd0);

    // Reset mid-operation drops the tag; the late response is an orphan
    do_reset();
    check("orphan_err_cleared", 64'(err_orphan), 64'd0);
    drive_req(0, 1'b0, 64'h9000);
    out_req_grant = 1'b1;
    tick();
    do_reset();
    check("midreset_outstanding", 64'(outstanding), 64'd0);
    drive_resp(64'h33);
    in_resp_grants = 2'b11;
    settle();
    check("midreset_resps_invalid", 64'({in_resps[1].valid, in_resps[0].valid}), 64'd0);
    tick();
    idle_inputs();
    settle();
    check("midreset_err_orphan", 64'(err_orphan), 64'd1);

    // Final report
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
